// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like bus bundle: req/addr_ok accepts a request, data_ok returns its response.
// The master side issues requests; the slave side accepts them and returns rdata.
interface sram_bus_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        addr_ok;
   logic        data_ok;

   modport master (
      output req, wr, size, addr, wdata,
      input  rdata, addr_ok, data_ok
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output rdata, addr_ok, data_ok
   );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-to-one SRAM-bus arbiter: instruction fetch and MEM-stage data share one master port,
// one transaction outstanding, data preferred with bounded starvation of instruction fetch.
module sram_bus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   sram_bus_arbiter_if.slave  inst,
   sram_bus_arbiter_if.slave  data,
   sram_bus_arbiter_if.master m,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state_q, state_d;
   logic       owner_q, owner_d;   // 0: inst, 1: data
   logic [3:0] starve_q, starve_d;
   logic       own_req;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   assign inst.rdata = m.rdata;
   assign data.rdata = m.rdata;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      starve_d     = starve_q;
      m.req        = 1'b0;
      m.wr         = 1'b0;
      m.size       = '0;
      m.addr       = '0;
      m.wdata      = '0;
      inst.addr_ok = 1'b0;
      inst.data_ok = 1'b0;
      data.addr_ok = 1'b0;
      data.data_ok = 1'b0;
      busy         = (state_q != IDLE);
      own_req      = owner_q ? data.req : inst.req;

      case (state_q)
         IDLE: begin
            // inst is forced through once data has won LIMIT times in a row while it waited
            if (data.req && !(inst.req && starve_q == LIMIT)) begin
               owner_d = 1'b1;
               state_d = REQ;
               if (inst.req)
                  starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
               else
                  starve_d = '0;
            end else if (inst.req) begin
               owner_d  = 1'b0;
               state_d  = REQ;
               starve_d = '0;
            end
         end

         REQ: begin
            m.req   = own_req;
            m.wr    = owner_q ? data.wr    : inst.wr;
            m.size  = owner_q ? data.size  : inst.size;
            m.addr  = owner_q ? data.addr  : inst.addr;
            m.wdata = owner_q ? data.wdata : inst.wdata;
            if (!own_req) begin
               state_d = IDLE;
            end else if (m.addr_ok) begin
               inst.addr_ok = !owner_q;
               data.addr_ok = owner_q;
               state_d      = RESP;
            end
         end

         RESP: begin
            if (m.data_ok) begin
               inst.data_ok = !owner_q;
               data.data_ok = owner_q;
               state_d      = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule
